// File: rtl/icache_dm2w_if.sv
`default_nettype none
// icache_dm2w_if: fetch-side request/response and memory-side read port of the instruction cache.
interface icache_dm2w_if #(
  parameter int WORD_W = 32
);
  logic              halt;
  logic              imemREN;
  logic [WORD_W-1:0] imemaddr;
  logic              ihit;
  logic [WORD_W-1:0] imemload;
  logic              iwait;
  logic [WORD_W-1:0] iload;
  logic              iREN;
  logic [WORD_W-1:0] iaddr;

  modport slave (
    input  halt, imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output halt, imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface
`default_nettype wire

// File: rtl/icache_dm2w.sv
`default_nettype none
// icache_dm2w: read-only direct-mapped instruction cache with 2-word blocks.
// Hits resolve combinationally; a miss fills both words of the block through a 3-state FSM.
module icache_dm2w #(
  parameter int SETS   = 8,
  parameter int WORD_W = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  icache_dm2w_if.slave bus
);
  localparam int IW = $clog2(SETS);
  localparam int TW = WORD_W - IW - 3;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FETCH0 = 2'd1;
  localparam logic [1:0] FETCH1 = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [SETS-1:0]   valid_q;
  logic [TW-1:0]     tag_q   [SETS];
  logic [WORD_W-1:0] word0_q [SETS];
  logic [WORD_W-1:0] word1_q [SETS];
  logic [TW+IW-1:0]  miss_q, miss_d;
  logic [WORD_W-1:0] buf_q, buf_d;

  logic [IW-1:0]     req_idx;
  logic [TW-1:0]     req_tag;
  logic              req_boff;
  logic [IW-1:0]     miss_idx;
  logic [TW-1:0]     miss_tag;
  logic              hit;
  logic              fill_done;
  logic              unused_byte_off;

  assign req_idx         = bus.imemaddr[IW+2:3];
  assign req_tag         = bus.imemaddr[WORD_W-1:IW+3];
  assign req_boff        = bus.imemaddr[2];
  assign unused_byte_off = ^bus.imemaddr[1:0];
  assign miss_idx        = miss_q[IW-1:0];
  assign miss_tag        = miss_q[TW+IW-1:IW];

  assign hit = (state_q == IDLE) && bus.imemREN && !bus.halt &&
               valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  assign bus.ihit     = hit;
  assign bus.imemload = hit ? (req_boff ? word1_q[req_idx] : word0_q[req_idx]) : '0;
  assign fill_done    = (state_q == FETCH1) && !bus.iwait;

  // Once a fill starts it only looks at the latched block address and iwait,
  // so halt or a changing request cannot abort it.
  always_comb begin
    state_d  = state_q;
    miss_d   = miss_q;
    buf_d    = buf_q;
    bus.iREN  = 1'b0;
    bus.iaddr = '0;
    case (state_q)
      IDLE: begin
        if (bus.imemREN && !bus.halt && !hit) begin
          miss_d  = {req_tag, req_idx};
          state_d = FETCH0;
        end
      end
      FETCH0: begin
        bus.iREN  = 1'b1;
        bus.iaddr = {miss_q, 1'b0, 2'b00};
        if (!bus.iwait) begin
          buf_d   = bus.iload;
          state_d = FETCH1;
        end
      end
      FETCH1: begin
        bus.iREN  = 1'b1;
        bus.iaddr = {miss_q, 1'b1, 2'b00};
        if (!bus.iwait) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      miss_q  <= '0;
      buf_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      miss_q  <= miss_d;
      buf_q   <= buf_d;
      if (fill_done) begin
        valid_q[miss_idx] <= 1'b1;
      end
    end
  end

  // Frame payload is qualified by valid_q, so it carries no reset.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tag_q[miss_idx]   <= miss_tag;
      word0_q[miss_idx] <= buf_q;
      word1_q[miss_idx] <= bus.iload;
    end
  end
endmodule
`default_nettype wire

// File: doc/icache_dm2w.md
Name: icache_dm2w

Overview:
- Direct-mapped instruction cache between the datapath's instruction-fetch side (datapath_cache_if icache modport) and the memory arbiter's instruction port.
- Serves imemaddr lookups with a combinational hit.
- On a miss, fills a 2-word block from memory with a 3-state FSM and latches the miss address.
- Read-only, so it never writes back.

Parameters:
- SETS, 8, number of frames (power of 2, ≥2); index width IW = log2(SETS).
- WORD_W, 32, word width; address width also WORD_W.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- nRST  input  1  asynchronous active-low reset.
- halt  input  1  datapath halted; stops new fills.
- imemREN  input  1  datapath instruction read request.
- imemaddr  input  32  byte address of the requested instruction.
- ihit  output  1  imemload valid this cycle.
- imemload  output  32  instruction word.
- iwait  input  1  memory busy; the access completes in a cycle where iwait=0 and iREN=1.
- iload  input  32  memory read data.
- iREN  output  1  memory read request.
- iaddr  output  32  memory byte address.

Behaviour:
- Reset and clocking: one clock (CLK); reset nRST is asynchronous, active-low.
- Address split: [1:0] byte offset (ignored), [2] block offset, [IW+2:3] index, [31:IW+3] tag.
- Frame contents: valid bit, tag, word0, word1.
- Reset (nRST=0, asynchronous, effective at any time including mid-fill):
  - all valid bits = 0; state = IDLE; latched miss address = 0; fill buffer = 0.
  - Outputs: ihit=0, iREN=0, iaddr=0, imemload=0.
- States: IDLE, FETCH0, FETCH1.
- Hit, combinational:
  - ihit = (state==IDLE) & imemREN & !halt & valid[idx] & (tag[idx]==addr tag).
  - imemload = selected word of frame[idx] when ihit, else 0.
  - Zero-cycle hit latency.
- IDLE:
  - imemREN & !halt & !hit: latch {tag,idx}, go to FETCH0.
  - Otherwise stay in IDLE.
  - iREN=0, iaddr=0.
- FETCH0:
  - iREN=1, iaddr={latched tag,idx,1'b0,2'b00}.
  - When iwait=0: capture iload into buffer word0, go to FETCH1.
  - While iwait=1: hold.
- FETCH1:
  - iREN=1, iaddr={latched tag,idx,1'b1,2'b00}.
  - When iwait=0: write frame[idx] = {valid=1, tag, word0, iload}, go to IDLE.
  - The originally requested access then hits on the next cycle if still presented.
- Miss latency with zero memory wait states: miss seen in cycle N, FETCH0 in N+1, FETCH1 in N+2, ihit in N+3.
- ihit is always 0 outside IDLE, even if the requested address is resident.
- A fill, once started, always completes:
  - imemREN deassertion or an imemaddr change mid-fill does not abort it.
  - The fill uses the latched address, not the live imemaddr.
- halt:
  - In IDLE: ihit=0 and no fill starts.
  - In FETCH0/FETCH1: the current fill completes, then the FSM stays in IDLE.
- Conflict miss overwrites the frame unconditionally; no eviction traffic.
- Valid bits are never cleared except by reset.

Test Plan:
- Reset, then imemREN=1, imemaddr=0x00000004, memory 0 waits returning 0xAAAA0000 at 0x0 and 0xBBBB0004 at 0x4:
  - iREN high for exactly 2 cycles, iaddr 0x0 then 0x4.
  - ihit=1 with imemload=0xBBBB0004 on the 4th cycle.
- Same block, imemaddr=0x00000000 after the fill -> ihit=1 same cycle, imemload=0xAAAA0000, iREN stays 0.
- Conflict miss with SETS=8: 0x00000040 maps to idx 0 with a different tag -> refill from 0x40/0x44. A later access to 0x0 misses again.
- Memory with 3 wait states per word:
  - iaddr held at 0x40 while iwait=1, then 0x44.
  - ihit arrives 9 cycles after the miss; ihit=0 throughout.
- During FETCH0, change imemaddr to 0x100 and drop imemREN:
  - fill of 0x40 block completes.
  - 0x100 then misses separately once requested.
- Assert nRST low mid-FETCH1 -> iREN=0 and ihit=0 immediately. After release, the prior-resident 0x0 misses.
- halt=1 in IDLE on a missing address -> no iREN, ihit=0 indefinitely.
